// File: rtl/jellyvl_etherneco_synctimer_cmd_decoder.sv
// jellyvl_etherneco_synctimer_cmd_decoder: receives a 13-byte synctimer command, stamps it against the local timer and reports the time error
module jellyvl_etherneco_synctimer_cmd_decoder #(
  parameter int TIMER_WIDTH  = 64,
  parameter int OFFSET_WIDTH = 32
) (
  input  logic                    reset_n_i,
  input  logic                    clk_i,
  input  logic [TIMER_WIDTH-1:0]  current_time_i,
  input  logic                    rx_start_i,
  input  logic                    rx_end_i,
  input  logic                    rx_error_i,
  input  logic [15:0]             payload_pos_i,
  input  logic [7:0]              payload_data_i,
  input  logic                    payload_valid_i,
  output logic                    cmd_valid_o,
  output logic                    cmd_override_o,
  output logic [TIMER_WIDTH-1:0]  cmd_time_o,
  output logic [OFFSET_WIDTH-1:0] cmd_offset_o,
  output logic [TIMER_WIDTH-1:0]  cmd_local_time_o,
  output logic [TIMER_WIDTH-1:0]  cmd_error_o,
  output logic [7:0]              drop_count_o
);
  typedef enum logic [1:0] {IDLE, RECV, CALC, OUT} state_t;
  state_t                  state_q, state_d;
  logic [12:0][7:0]        pl_q, pl_d;
  logic [12:0]             mask_q, mask_d;
  logic                    over_q, over_d;
  logic [TIMER_WIDTH-1:0]  cap_q, cap_d;
  logic [7:0]              drop_q, drop_d;
  logic                    drop;
  logic [TIMER_WIDTH-1:0]  target;
  logic                    in_range;
  assign in_range = payload_pos_i < 16'd13;
  // target time of the buffered frame; only the low TIMER_WIDTH bits of the remote time are kept
  assign target = TIMER_WIDTH'(pl_q[8:1]) + TIMER_WIDTH'({32'd0, pl_q[12:9]});
  assign drop_d = (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  // frame assembly, validation and sequencing; the byte of an rx_end cycle lands before the length check
  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    mask_d  = mask_q;
    over_d  = over_q;
    cap_d   = cap_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_start_i) begin
          state_d = RECV;
          mask_d  = '0;
          over_d  = 1'b0;
        end
      end
      RECV: begin
        if (payload_valid_i) begin
          if (in_range) begin
            pl_d[payload_pos_i[3:0]]   = payload_data_i;
            mask_d[payload_pos_i[3:0]] = 1'b1;
          end else over_d = 1'b1;
          if (payload_pos_i == 16'd0) cap_d = current_time_i;
        end
        if (rx_start_i) begin
          drop   = 1'b1;
          mask_d = '0;
          over_d = 1'b0;
        end else if (rx_error_i) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if (rx_end_i) begin
          state_d = (&mask_d && !over_d && pl_d[0][7:1] == 7'd0) ? CALC : IDLE;
          drop    = !(&mask_d && !over_d && pl_d[0][7:1] == 7'd0);
        end
      end
      CALC:    state_d = OUT;
      default: state_d = IDLE;
    endcase
  end
  // receive-side state; the frame buffer is kept apart from the published command
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      pl_q    <= '0;
      mask_q  <= '0;
      over_q  <= 1'b0;
      cap_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      mask_q  <= mask_d;
      over_q  <= over_d;
      cap_q   <= cap_d;
      drop_q  <= drop_d;
    end
  end
  // publish the command so that all fields become visible together with cmd_valid in OUT
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_valid_o      <= 1'b0;
      cmd_override_o   <= 1'b0;
      cmd_time_o       <= '0;
      cmd_offset_o     <= '0;
      cmd_local_time_o <= '0;
      cmd_error_o      <= '0;
    end else begin
      cmd_valid_o <= state_q == CALC;
      if (state_q == CALC) begin
        cmd_override_o   <= pl_q[0] == 8'h01;
        cmd_time_o       <= TIMER_WIDTH'(pl_q[8:1]);
        cmd_offset_o     <= OFFSET_WIDTH'(pl_q[12:9]);
        cmd_local_time_o <= cap_q;
        cmd_error_o      <= target - cap_q;
      end
    end
  end
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_cmd_decoder.sv
// tb_jellyvl_etherneco_synctimer_cmd_decoder: scoreboard bench with a byte-map reference model
module tb_jellyvl_etherneco_synctimer_cmd_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ct = '0;
  logic        rx_start = 1'b0, rx_end = 1'b0, rx_error = 1'b0, pv = 1'b0;
  logic [15:0] pos = '0;
  logic [7:0]  pd = '0;
  logic        cmd_valid, cmd_override;
  logic [63:0] cmd_time, cmd_local_time, cmd_error;
  logic [31:0] cmd_offset;
  logic [7:0]  drop_count;

  jellyvl_etherneco_synctimer_cmd_decoder #(.TIMER_WIDTH(64), .OFFSET_WIDTH(32)) dut (
    .reset_n_i(rst_n), .clk_i(clk), .current_time_i(ct),
    .rx_start_i(rx_start), .rx_end_i(rx_end), .rx_error_i(rx_error),
    .payload_pos_i(pos), .payload_data_i(pd), .payload_valid_i(pv),
    .cmd_valid_o(cmd_valid), .cmd_override_o(cmd_override), .cmd_time_o(cmd_time),
    .cmd_offset_o(cmd_offset), .cmd_local_time_o(cmd_local_time), .cmd_error_o(cmd_error),
    .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ov;
    logic [63:0] t;
    logic [31:0] o;
    logic [63:0] lt;
    logic [63:0] e;
    int          cy;
  } exp_t;

  exp_t        q[$];
  exp_t        last = '0;
  int          cyc = 0;
  int          compared = 0, mismatched = 0;
  int          drop_exp = 0;
  int          fpos[$];
  logic [7:0]  fdat[$];
  logic        fix_en = 1'b0;
  logic [63:0] fix_ct = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_cmd_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        me = q.pop_front();
        chk("latency_cycle", 64'(cyc), 64'(me.cy));
        chk("cmd_override", {63'd0, cmd_override}, {63'd0, me.ov});
        chk("cmd_time", cmd_time, me.t);
        chk("cmd_offset", {32'd0, cmd_offset}, {32'd0, me.o});
        chk("cmd_local_time", cmd_local_time, me.lt);
        chk("cmd_error", cmd_error, me.e);
      end
    end
  end

  task automatic zero_check(input string nm);
    chk({nm, "_valid"}, {63'd0, cmd_valid}, 64'd0);
    chk({nm, "_override"}, {63'd0, cmd_override}, 64'd0);
    chk({nm, "_time"}, cmd_time, 64'd0);
    chk({nm, "_offset"}, {32'd0, cmd_offset}, 64'd0);
    chk({nm, "_local"}, cmd_local_time, 64'd0);
    chk({nm, "_error"}, cmd_error, 64'd0);
    chk({nm, "_drop"}, {56'd0, drop_count}, 64'd0);
  endtask

  task automatic model_reset();
    q.delete();
    last = '0;
    drop_exp = 0;
  endtask

  task automatic build(input logic [7:0] id, input logic [63:0] t, input logic [31:0] o);
    logic [103:0] v;
    v = {o, t, id};
    fpos.delete();
    fdat.delete();
    for (int i = 0; i < 13; i++) begin
      fpos.push_back(i);
      fdat.push_back(v[i*8 +: 8]);
    end
  endtask

  // mode 0: normal, 1: async reset mid-frame, 2: async reset during the OUT cycle
  task automatic send(input bit err, input int mode, input bit tail);
    logic [7:0]  m[13];
    bit          seen[13];
    bit          over, all_seen, accept;
    logic [63:0] cap, t;
    logic [31:0] o;
    exp_t        e;
    int          n, p, end_cyc;
    over = 0;
    cap = '0;
    for (int k = 0; k < 13; k++) begin
      m[k] = '0;
      seen[k] = 0;
    end
    @(posedge clk); #1 rx_start = 1'b1;
    @(posedge clk); #1 rx_start = 1'b0;
    n = fpos.size();
    end_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i == n / 2) begin
        #2 rst_n = 1'b0;
        #1 zero_check("reset_mid_frame");
        rst_n = 1'b1;
        model_reset();
      end
      p = fpos[i];
      pv = 1'b1;
      pos = 16'(p);
      pd = fdat[i];
      ct = (p == 0 && fix_en) ? fix_ct : {$urandom, $urandom};
      if (p < 13) begin
        m[p] = fdat[i];
        seen[p] = 1;
      end else over = 1;
      if (p == 0) cap = ct;
      rx_end = tail && i == n - 1;
      rx_error = err && rx_end;
      end_cyc = cyc;
      @(posedge clk); #1;
      pv = 1'b0;
      rx_end = 1'b0;
      rx_error = 1'b0;
    end
    if (!tail || n == 0) begin
      rx_end = 1'b1;
      rx_error = err;
      end_cyc = cyc;
      @(posedge clk); #1;
      rx_end = 1'b0;
      rx_error = 1'b0;
    end
    all_seen = 1;
    for (int k = 0; k < 13; k++) all_seen = all_seen && seen[k];
    accept = !err && all_seen && !over && m[0] <= 8'h01;
    if (mode != 1) begin
      if (accept) begin
        t = '0;
        o = '0;
        for (int k = 1; k <= 8; k++) t[(k-1)*8 +: 8] = m[k];
        for (int k = 9; k <= 12; k++) o[(k-9)*8 +: 8] = m[k];
        e.ov = m[0] == 8'h01;
        e.t = t;
        e.o = o;
        e.lt = cap;
        e.e = t + {32'd0, o} - cap;
        e.cy = end_cyc + 2;
        if (mode == 2) begin
          @(posedge clk);
          #2 rst_n = 1'b0;
          #1 zero_check("reset_at_out");
          rst_n = 1'b1;
          model_reset();
        end else begin
          q.push_back(e);
          last = e;
        end
      end else if (drop_exp < 255) drop_exp++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("pending_expectations", 64'(q.size()), 64'd0);
    chk("drop_count", {56'd0, drop_count}, 64'(drop_exp));
    chk("hold_override", {63'd0, cmd_override}, {63'd0, last.ov});
    chk("hold_error", cmd_error, last.e);
    chk("hold_local_time", cmd_local_time, last.lt);
  endtask

  initial begin
    int j, tmp_p;
    logic [7:0] tmp_d;
    repeat (3) @(posedge clk);
    #1 zero_check("reset_state");
    rst_n = 1'b1;
    fix_en = 1'b1;
    fix_ct = 64'h0F00;
    build(8'h01, 64'h1000, 32'd1000);
    send(0, 0, 0);
    chk("normal_error", cmd_error, 64'h4E8);
    chk("normal_override", {63'd0, cmd_override}, 64'd1);
    fix_ct = 64'h200;
    build(8'h00, 64'h100, 32'd0);
    send(0, 0, 1);
    chk("negative_error", cmd_error, 64'hFFFF_FFFF_FFFF_FF00);
    build(8'h01, 64'h55, 32'd7);
    void'(fpos.pop_back());
    void'(fdat.pop_back());
    send(0, 0, 0);
    build(8'h01, 64'h55, 32'd7);
    fpos.push_back(13);
    fdat.push_back(8'hAA);
    send(0, 0, 1);
    chk("short_long_drops", {56'd0, drop_count}, 64'd2);
    build(8'h01, 64'h77, 32'd3);
    send(1, 0, 1);
    build(8'h02, 64'h77, 32'd3);
    send(0, 0, 0);
    chk("error_badid_drops", {56'd0, drop_count}, 64'd4);
    fix_ct = 64'h0;
    build(8'h01, 64'hFFFF_FFFF_FFFF_FFF0, 32'h20);
    send(0, 0, 0);
    chk("wrap_error", cmd_error, 64'h10);
    fix_en = 1'b0;
    build(8'h01, 64'h1234, 32'd9);
    send(0, 1, 0);
    build(8'h00, 64'h9999, 32'd5);
    send(0, 0, 0);
    build(8'h01, 64'hABCD, 32'd11);
    send(0, 2, 1);
    build(8'h01, 64'h4321, 32'd2);
    send(0, 0, 1);
    for (int r = 0; r < 60; r++) begin
      build(8'($urandom_range(2)), {$urandom, $urandom}, $urandom);
      for (int i = 0; i < 13; i++) begin
        j = $urandom_range(12);
        tmp_p = fpos[i]; fpos[i] = fpos[j]; fpos[j] = tmp_p;
        tmp_d = fdat[i]; fdat[i] = fdat[j]; fdat[j] = tmp_d;
      end
      if ($urandom_range(3) == 0) begin
        fpos.push_back($urandom_range(12));
        fdat.push_back(8'($urandom));
      end
      if ($urandom_range(7) == 0) begin
        void'(fpos.pop_front());
        void'(fdat.pop_front());
      end
      if ($urandom_range(7) == 0) begin
        fpos.push_back(13 + $urandom_range(20));
        fdat.push_back(8'($urandom));
      end
      send($urandom_range(9) == 0, 0, $urandom_range(1) == 1);
    end
    fpos.delete();
    fdat.delete();
    for (int r = 0; r < 300; r++) send(0, 0, 0);
    chk("drop_saturated", {56'd0, drop_count}, 64'd255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/jellyvl_etherneco_synctimer_cmd_decoder.md
# jellyvl_etherneco_synctimer_cmd_decoder

Slave-side receiver for the synctimer command packet produced by the master's command transmitter. It sits downstream of the ring payload parser and consumes the 13-byte payload (command_id, 64-bit time, 32-bit offset), time-stamps it against the local timer, and validates the frame. It then emits the decoded command plus the signed time error that the slave timer adjuster consumes.

## Interface
- TIMER_WIDTH, 64, local/remote timer width (1..64); received time is truncated to the low TIMER_WIDTH bits
- OFFSET_WIDTH, 32, offset field width; fixed by packet format, must be 32
- reset  input  1  asynchronous, active-low reset
- clk  input  1  clock
- current_time  input  TIMER_WIDTH  local timer value
- rx_start  input  1  frame start pulse
- rx_end  input  1  frame end pulse
- rx_error  input  1  frame error pulse (CRC/format)
- payload_pos  input  16  byte index in payload
- payload_data  input  8  payload byte
- payload_valid  input  1  payload byte strobe
- cmd_valid  output  1  one-cycle pulse, decoded command available
- cmd_override  output  1  command_id == 8'h01
- cmd_time  output  TIMER_WIDTH  remote time field
- cmd_offset  output  32  offset field
- cmd_local_time  output  TIMER_WIDTH  current_time captured at payload byte 0
- cmd_error  output  TIMER_WIDTH  signed (cmd_time + cmd_offset) − cmd_local_time, modulo 2^TIMER_WIDTH
- drop_count  output  8  saturating count of rejected frames

## Operation
- Packet format, little-endian: pos 0 command_id; pos 1..8 time (pos 1 = LSB); pos 9..12 offset (pos 9 = LSB). Valid length exactly 13.
- FSM states: IDLE, RECV, CALC, OUT.
- IDLE: on rx_start → RECV; clear byte-seen mask (13 bits) and overlength flag.
- RECV: each payload_valid writes payload_data into field byte at payload_pos and sets mask bit; pos ≥ 13 sets overlength, data ignored. On pos 0, current_time latched into capture register.
- RECV exits: rx_error → IDLE, drop. rx_end with mask ≠ all-ones, overlength set, or command_id ∉ {00,01} → IDLE, drop. rx_end otherwise → CALC.
- CALC: target = cmd_time + zero-extended cmd_offset (mod 2^TIMER_WIDTH) registered → OUT.
- OUT: cmd_error = target − capture registered; cmd_valid = 1 this cycle → IDLE.
- cmd_time/offset/override/local_time/error hold their values until the next accepted frame; they update only in OUT. Rejected frames never alter them.
- drop_count increments by 1 per rejected frame, saturates at 255, clears only on reset.

## Timing
- Reset (asserted low, asynchronous): state IDLE, cmd_valid 0, all cmd_* outputs 0, drop_count 0, mask 0.
- Latency: cmd_valid asserted exactly 2 cycles after the rx_end cycle (rx_end at cycle N → CALC N+1 → cmd_valid at N+2).
- payload_valid and rx_end in the same cycle: byte is written first, then length check uses the updated mask.
- rx_error and rx_end in same cycle: drop (error wins).
- rx_start while in RECV: current frame dropped (drop_count +1), receive restarts in same cycle.
- rx_start during CALC/OUT: ignored; frame not received (no drop count). Upstream guarantees ≥2 idle cycles between frames.
- Duplicate pos within a frame: last write wins, not an error.
- Capture uses current_time of the cycle payload_pos==0 is valid, not registered further.
- Reset deasserted mid-frame: block stays IDLE until the next rx_start.
- No backpressure; block accepts one byte per cycle unconditionally.

## Test plan
- Normal frame: id 01, time 0x0000_0000_0000_1000, offset 1000, current_time 0x0F00 at pos 0 → cmd_valid at rx_end+2, override 1, cmd_time 0x1000, cmd_offset 1000, cmd_local_time 0x0F00, cmd_error 0x4E8 (1256).
- Negative error: id 00, time 0x100, offset 0, capture 0x200 → cmd_override 0, cmd_error 0xFFFF_FFFF_FFFF_FF00 (−256).
- Short frame (12 bytes) then long frame (14 bytes) → no cmd_valid, drop_count 2, outputs keep prior values.
- rx_error asserted with rx_end on valid 13 bytes; and id 0x02 frame → no cmd_valid, drop_count +1 each.
- Wrap-around: time 0xFFFF_FFFF_FFFF_FFF0, offset 0x20, capture 0 → cmd_error 0x10.
- Async reset pulse low during RECV and at OUT cycle → cmd_valid 0 immediately, all outputs 0; following clean frame decodes normally; 300 bad frames → drop_count 255.
